// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned DEF_PC_WIDTH     = 8;
    localparam int unsigned DEF_INSTR_WIDTH  = 16;
    localparam int unsigned DEF_OPCODE_WIDTH = 4;

    localparam int unsigned OP_ALU_LO = 0;
    localparam int unsigned OP_ALU_HI = 7;
    localparam int unsigned OP_LD     = 8;
    localparam int unsigned OP_ST     = 9;
    localparam int unsigned OP_JMP    = 10;
    localparam int unsigned OP_CJMP   = 11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LOAD  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control-FSM / ROM side bundle of the fetch stage; master = controller+ROM, slave = fetch unit.
interface pc_fetch_unit_if #(
    parameter int unsigned PC_WIDTH    = fetch_pkg::DEF_PC_WIDTH,
    parameter int unsigned INSTR_WIDTH = fetch_pkg::DEF_INSTR_WIDTH
);
    logic                   enablePC;
    logic                   enableJUMP;
    logic                   enableCMPJUMP;
    logic                   nextInstruction;
    logic [INSTR_WIDTH-1:0] instrData;
    logic [PC_WIDTH-1:0]    instrAddr;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instrValid;
    logic                   alu;
    logic                   ld;
    logic                   st;
    logic                   jump;
    logic                   cmpJump;
    logic                   halted;

    modport master (
        output enablePC, enableJUMP, enableCMPJUMP, nextInstruction, instrData,
        input  instrAddr, instr, instrValid, alu, ld, st, jump, cmpJump, halted
    );

    modport slave (
        input  enablePC, enableJUMP, enableCMPJUMP, nextInstruction, instrData,
        output instrAddr, instr, instrValid, alu, ld, st, jump, cmpJump, halted
    );
endinterface

// File: rtl/opcode_class_decoder.sv
// Maps an opcode to its one-hot instruction class; opcodes above OP_CJMP flag illegal.
module opcode_class_decoder
    import fetch_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = DEF_OPCODE_WIDTH
) (
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic                    i_valid,
    output logic                    o_alu,
    output logic                    o_ld,
    output logic                    o_st,
    output logic                    o_jump,
    output logic                    o_cmp_jump,
    output logic                    o_illegal
);

    always_comb begin
        o_alu      = 1'b0;
        o_ld       = 1'b0;
        o_st       = 1'b0;
        o_jump     = 1'b0;
        o_cmp_jump = 1'b0;
        o_illegal  = 1'b0;
        if (i_valid) begin
            if (i_opcode <= OPCODE_WIDTH'(OP_ALU_HI)) begin
                o_alu = 1'b1;
            end else if (i_opcode == OPCODE_WIDTH'(OP_LD)) begin
                o_ld = 1'b1;
            end else if (i_opcode == OPCODE_WIDTH'(OP_ST)) begin
                o_st = 1'b1;
            end else if (i_opcode == OPCODE_WIDTH'(OP_JMP)) begin
                o_jump = 1'b1;
            end else if (i_opcode == OPCODE_WIDTH'(OP_CJMP)) begin
                o_cmp_jump = 1'b1;
            end else begin
                o_illegal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, synchronous-ROM fetch into IR, and class decode for the control FSM.
// FETCH_ILLEGAL_HALT_EN: illegal opcodes park the unit in S_HALT until reset instead of being skipped.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = DEF_PC_WIDTH,
    parameter int unsigned INSTR_WIDTH  = DEF_INSTR_WIDTH,
    parameter int unsigned OPCODE_WIDTH = DEF_OPCODE_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    pc_fetch_unit_if.slave bus
);

    logic [PC_WIDTH-1:0]     r_pc;
    logic [INSTR_WIDTH-1:0]  r_ir;
    fetch_state_t            r_state;
    logic                    r_valid;

    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic [PC_WIDTH-1:0]     w_target;
    logic [PC_WIDTH-1:0]     w_pc_inc;
    logic                    w_redirect;
    logic                    w_step;
    logic                    w_illegal;

    assign w_opcode   = r_ir[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign w_target   = r_ir[PC_WIDTH-1:0];
    assign w_pc_inc   = r_pc + PC_WIDTH'(1);
    assign w_redirect = bus.enablePC & (bus.enableJUMP | bus.enableCMPJUMP);
    assign w_step     = bus.enablePC & bus.nextInstruction;

`ifdef FETCH_ILLEGAL_HALT_EN
    logic r_halted;
`endif

    // Sequencer: ROM data lands one cycle after the address, so FETCH -> LOAD -> ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= '0;
            r_ir    <= '0;
            r_state <= S_FETCH;
            r_valid <= 1'b0;
`ifdef FETCH_ILLEGAL_HALT_EN
            r_halted <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_ir    <= bus.instrData;
                    r_state <= S_ISSUE;
                    r_valid <= 1'b1;
                end
                S_ISSUE: begin
                    if (w_illegal) begin
`ifdef FETCH_ILLEGAL_HALT_EN
                        r_state  <= S_HALT;
                        r_valid  <= 1'b0;
                        r_halted <= 1'b1;
`else
                        r_pc    <= w_pc_inc;
                        r_state <= S_FETCH;
                        r_valid <= 1'b0;
`endif
                    end else if (w_redirect) begin
                        r_pc    <= w_target;
                        r_state <= S_FETCH;
                        r_valid <= 1'b0;
                    end else if (w_step) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_FETCH;
                        r_valid <= 1'b0;
                    end
                end
                S_HALT: begin
`ifndef FETCH_ILLEGAL_HALT_EN
                    r_state <= S_FETCH;
                    r_valid <= 1'b0;
`endif
                end
                default: begin
                    r_state <= S_FETCH;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    opcode_class_decoder #(
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_decoder (
        .i_opcode   (w_opcode),
        .i_valid    (r_valid),
        .o_alu      (bus.alu),
        .o_ld       (bus.ld),
        .o_st       (bus.st),
        .o_jump     (bus.jump),
        .o_cmp_jump (bus.cmpJump),
        .o_illegal  (w_illegal)
    );

    assign bus.instrAddr  = r_pc;
    assign bus.instr      = r_ir;
    assign bus.instrValid = r_valid;
`ifdef FETCH_ILLEGAL_HALT_EN
    assign bus.halted = r_halted;
`else
    assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a synchronous ROM model; follows FETCH_ILLEGAL_HALT_EN.
module tb_pc_fetch_unit;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    pc_fetch_unit_if bus ();

    pc_fetch_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Status vector: {instrValid, alu, ld, st, jump, cmpJump, halted}
    localparam logic [6:0] V_NONE = 7'b0000000;
    localparam logic [6:0] V_ALU  = 7'b1100000;
    localparam logic [6:0] V_LD   = 7'b1010000;
    localparam logic [6:0] V_ST   = 7'b1001000;
    localparam logic [6:0] V_JMP  = 7'b1000100;
    localparam logic [6:0] V_CJ   = 7'b1000010;
    localparam logic [6:0] V_ILL  = 7'b1000000;
    localparam logic [6:0] V_HALT = 7'b0000001;

    logic [6:0]  obs;
    logic [15:0] rom [256];

    assign obs = {bus.instrValid, bus.alu, bus.ld, bus.st, bus.jump, bus.cmpJump, bus.halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.instrData <= rom[bus.instrAddr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic jmp, input logic cj, input logic nxt);
        bus.enablePC        = en;
        bus.enableJUMP      = jmp;
        bus.enableCMPJUMP   = cj;
        bus.nextInstruction = nxt;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (obs !== V_NONE || bus.instrAddr !== 8'h00 || bus.instr !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_state: status=%b addr=%h ir=%h, want %b 00 0000", obs, bus.instrAddr, bus.instr, V_NONE);
        end
        tick();
        n_cmp++;
        if (obs !== V_NONE || bus.instrAddr !== 8'h00) begin
            n_err++;
            $display("FAIL reset_load: status=%b addr=%h, want %b 00", obs, bus.instrAddr, V_NONE);
        end
        tick();
        n_cmp++;
        if (obs !== V_ALU || bus.instr !== 16'h1005) begin
            n_err++;
            $display("FAIL reset_issue: status=%b ir=%h, want %b 1005", obs, bus.instr, V_ALU);
        end
        // Requests without enablePC must be ignored.
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== V_ALU || bus.instrAddr !== 8'h00) begin
            n_err++;
            $display("FAIL hold_no_enable: status=%b addr=%h, want %b 00", obs, bus.instrAddr, V_ALU);
        end
    endtask

    task automatic test_advance();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== V_NONE || bus.instrAddr !== 8'h01) begin
            n_err++;
            $display("FAIL advance_drop: status=%b addr=%h, want %b 01", obs, bus.instrAddr, V_NONE);
        end
        tick();
        n_cmp++;
        if (obs !== V_NONE) begin
            n_err++;
            $display("FAIL advance_gap: status=%b, want %b", obs, V_NONE);
        end
        tick();
        n_cmp++;
        if (obs !== V_LD || bus.instr !== 16'h8000) begin
            n_err++;
            $display("FAIL advance_ld: status=%b ir=%h, want %b 8000", obs, bus.instr, V_LD);
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        n_cmp++;
        if (obs !== V_ILL || bus.instrAddr !== 8'h02 || bus.instr !== 16'hC000) begin
            n_err++;
            $display("FAIL illegal_issue: status=%b addr=%h ir=%h, want %b 02 C000", obs, bus.instrAddr, bus.instr, V_ILL);
        end
`ifdef FETCH_ILLEGAL_HALT_EN
        tick();
        n_cmp++;
        if (obs !== V_HALT || bus.instrAddr !== 8'h02) begin
            n_err++;
            $display("FAIL halt_enter: status=%b addr=%h, want %b 02", obs, bus.instrAddr, V_HALT);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (obs !== V_HALT || bus.instrAddr !== 8'h02) begin
            n_err++;
            $display("FAIL halt_frozen: status=%b addr=%h, want %b 02", obs, bus.instrAddr, V_HALT);
        end
        do_reset();
        n_cmp++;
        if (obs !== V_NONE || bus.instrAddr !== 8'h00) begin
            n_err++;
            $display("FAIL halt_reset: status=%b addr=%h, want %b 00", obs, bus.instrAddr, V_NONE);
        end
`else
        tick();
        n_cmp++;
        if (obs !== V_NONE || bus.instrAddr !== 8'h03) begin
            n_err++;
            $display("FAIL illegal_skip: status=%b addr=%h, want %b 03", obs, bus.instrAddr, V_NONE);
        end
        tick();
        tick();
        n_cmp++;
        if (obs !== V_ST || bus.instr !== 16'h9000) begin
            n_err++;
            $display("FAIL illegal_next_st: status=%b ir=%h, want %b 9000", obs, bus.instr, V_ST);
        end
`endif
    endtask

    task automatic test_jump_chain();
        do_reset();
        tick();
        tick();
        // ALU word 0x1005 carries target 0x05 in its low byte.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.instrAddr !== 8'h05 || obs !== V_NONE) begin
            n_err++;
            $display("FAIL jump_to_5: status=%b addr=%h, want %b 05", obs, bus.instrAddr, V_NONE);
        end
        tick();
        tick();
        n_cmp++;
        if (obs !== V_JMP || bus.instr !== 16'hA03C) begin
            n_err++;
            $display("FAIL jump_issue: status=%b ir=%h, want %b A03C", obs, bus.instr, V_JMP);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.instrAddr !== 8'h3C || obs !== V_NONE) begin
            n_err++;
            $display("FAIL jump_priority: status=%b addr=%h, want %b 3C", obs, bus.instrAddr, V_NONE);
        end
        tick();
        n_cmp++;
        if (obs !== V_NONE) begin
            n_err++;
            $display("FAIL jump_drop2: status=%b, want %b", obs, V_NONE);
        end
        tick();
        n_cmp++;
        if (obs !== V_CJ || bus.instr !== 16'hB0FF) begin
            n_err++;
            $display("FAIL cmpjump_issue: status=%b ir=%h, want %b B0FF", obs, bus.instr, V_CJ);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.instrAddr !== 8'hFF) begin
            n_err++;
            $display("FAIL cmpjump_target: addr=%h, want FF", bus.instrAddr);
        end
        tick();
        tick();
        n_cmp++;
        if (obs !== V_ALU || bus.instr !== 16'h1234) begin
            n_err++;
            $display("FAIL rom_ff_issue: status=%b ir=%h, want %b 1234", obs, bus.instr, V_ALU);
        end
    endtask

    task automatic test_wrap_and_ignore();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (bus.instrAddr !== 8'h00 || obs !== V_NONE) begin
            n_err++;
            $display("FAIL pc_wrap: status=%b addr=%h, want %b 00", obs, bus.instrAddr, V_NONE);
        end
        // Requests held through FETCH/LOAD must not move the PC.
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        n_cmp++;
        if (bus.instrAddr !== 8'h00 || obs !== V_NONE) begin
            n_err++;
            $display("FAIL ignore_in_fetch: status=%b addr=%h, want %b 00", obs, bus.instrAddr, V_NONE);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (obs !== V_ALU || bus.instrAddr !== 8'h00 || bus.instr !== 16'h1005) begin
            n_err++;
            $display("FAIL wrap_issue: status=%b addr=%h ir=%h, want %b 00 1005", obs, bus.instrAddr, bus.instr, V_ALU);
        end
    endtask

    task automatic test_mid_reset();
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.instrAddr !== 8'h00 || obs !== V_NONE || bus.instr !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_reset: status=%b addr=%h ir=%h, want %b 00 0000", obs, bus.instrAddr, bus.instr, V_NONE);
        end
        tick();
        tick();
        n_cmp++;
        if (obs !== V_ALU || bus.instrAddr !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset_resume: status=%b addr=%h, want %b 00", obs, bus.instrAddr, V_ALU);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000;
        rom[8'h00] = 16'h1005;
        rom[8'h01] = 16'h8000;
        rom[8'h02] = 16'hC000;
        rom[8'h03] = 16'h9000;
        rom[8'h05] = 16'hA03C;
        rom[8'h3C] = 16'hB0FF;
        rom[8'hFF] = 16'h1234;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        test_reset();
        test_advance();
        test_illegal();
        test_jump_chain();
        test_wrap_and_ignore();
        test_mid_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
